// File: rtl/mti_frame_ctrl_pkg.sv
// Shared definitions for the MTI frame sequencer: state encodings, counter widths
// and configuration clamp helpers.
package mti_frame_ctrl_pkg;

    localparam int unsigned CNT_W    = 9;
    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned DATA_W   = 16;

    localparam logic [PERIOD_W-1:0] MIN_PERIOD = 16'd2;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ACQ        = 3'd1;
    localparam logic [2:0] S_WAIT_LAST  = 3'd2;
    localparam logic [2:0] S_DRAIN_REQ  = 3'd3;
    localparam logic [2:0] S_DRAIN_WAIT = 3'd4;
    localparam logic [2:0] S_DRAIN_OUT  = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    function automatic logic [CNT_W-1:0] clamp_nsamp(input logic [CNT_W-1:0] n,
                                                     input logic [CNT_W-1:0] max_n);
        return (n > max_n) ? max_n : n;
    endfunction

    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

endpackage

// File: rtl/mti_frame_ctrl_period_timer.sv
// mti_period_timer: saturating 16-bit cycles-since-restart counter; expire is high
// once the count has reached limit.
module mti_period_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic [15:0] limit,
    output logic        expire
);

    logic [15:0] count;

    // Restart loads 1 so the count equals cycles elapsed since the restart cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (restart) begin
            count <= 16'd1;
        end else if (count != '1) begin
            count <= count + 16'd1;
        end
    end

    assign expire = (count >= limit);

endmodule

// File: rtl/mti_frame_ctrl.sv
// MTI frame sequencer: paces adc_start, counts adc_done, then drains the ADC FIFO
// into a valid/ready stream. Define MTI_FRAME_TIMEOUT_EN to enable the ADC timeout.
module mti_frame_ctrl
    import mti_frame_ctrl_pkg::*;
#(
    parameter int unsigned MAX_SAMP    = 256,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cfg_period,
    input  logic [8:0]  cfg_nsamp,
    input  logic        frame_start,
    output logic        busy,
    output logic        frame_done,
    output logic        err_timeout,
    output logic        adc_start,
    input  logic        adc_done,
    output logic        fifo_rden,
    input  logic        fifo_rdstb,
    input  logic [15:0] fifo_rddata,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_SAMP);

    logic [2:0]          state;
    logic [PERIOD_W-1:0] period_q;
    logic [CNT_W-1:0]    nsamp_q;
    logic [CNT_W-1:0]    nsamp_in;
    logic [CNT_W-1:0]    issued;
    logic [CNT_W-1:0]    done_cnt;
    logic [CNT_W-1:0]    word_idx;
    logic                acq_phase;
    logic                credit;
    logic                done_ok;
    logic                period_exp;
    logic                fire;
    logic                timeout_hit;

    assign nsamp_in  = clamp_nsamp(cfg_nsamp, MAX_N);
    assign acq_phase = (state == S_ACQ) || (state == S_WAIT_LAST);

    // issued only counts starts from earlier cycles, so a done arriving in the same
    // cycle as a new start is credited to the previous start.
    assign credit  = acq_phase && adc_done && (done_cnt != issued);
    assign done_ok = (done_cnt == issued) || credit;
    assign fire    = (state == S_ACQ) && (issued != nsamp_q) &&
                     ((issued == '0) || (period_exp && done_ok));

    assign adc_start = fire;
    assign fifo_rden = (state == S_DRAIN_REQ);

    mti_period_timer u_period_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (fire),
        .limit   (period_q),
        .expire  (period_exp)
    );

`ifdef MTI_FRAME_TIMEOUT_EN
    logic timeout_exp;

    mti_period_timer u_timeout_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (fire),
        .limit   (16'(TIMEOUT_CYC)),
        .expire  (timeout_exp)
    );

    assign timeout_hit = acq_phase && (done_cnt != issued) && !adc_done && timeout_exp;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            period_q    <= '0;
            nsamp_q     <= '0;
            issued      <= '0;
            done_cnt    <= '0;
            word_idx    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (fire) begin
                issued <= issued + CNT_W'(1);
            end
            if (credit) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        period_q    <= clamp_period(cfg_period);
                        nsamp_q     <= nsamp_in;
                        issued      <= '0;
                        done_cnt    <= '0;
                        word_idx    <= '0;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (nsamp_in == '0) ? S_DONE : S_ACQ;
                    end
                end
                S_ACQ: begin
                    if (timeout_hit) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else if (fire && ((issued + CNT_W'(1)) == nsamp_q)) begin
                        state <= S_WAIT_LAST;
                    end
                end
                S_WAIT_LAST: begin
                    if (timeout_hit) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else if (done_cnt == nsamp_q) begin
                        state <= S_DRAIN_REQ;
                    end
                end
                S_DRAIN_REQ: begin
                    state <= S_DRAIN_WAIT;
                end
                S_DRAIN_WAIT: begin
                    if (fifo_rdstb) begin
                        out_data  <= fifo_rddata;
                        out_valid <= 1'b1;
                        out_last  <= (word_idx == (nsamp_q - CNT_W'(1)));
                        state     <= S_DRAIN_OUT;
                    end
                end
                S_DRAIN_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        word_idx  <= word_idx + CNT_W'(1);
                        state     <= out_last ? S_DONE : S_DRAIN_REQ;
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mti_frame_ctrl.sv
// Randomized self-checking bench for mti_frame_ctrl with a behavioural ADC/FIFO model.
// Timeout scenarios are exercised when MTI_FRAME_TIMEOUT_EN is defined.
module tb_mti_frame_ctrl;

    localparam int unsigned TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cfg_period;
    logic [8:0]  cfg_nsamp;
    logic        frame_start;
    logic        busy, frame_done, err_timeout, adc_start, adc_done;
    logic        fifo_rden, fifo_rdstb;
    logic [15:0] fifo_rddata, out_data;
    logic        out_valid, out_ready, out_last;

    always #5 clk = ~clk;

    mti_frame_ctrl #(
        .MAX_SAMP    (256),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_period  (cfg_period),
        .cfg_nsamp   (cfg_nsamp),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .fifo_rden   (fifo_rden),
        .fifo_rdstb  (fifo_rdstb),
        .fifo_rddata (fifo_rddata),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    int unsigned lat_q[$];
    int unsigned done_at[$];
    logic [15:0] fifo_q[$];
    logic [15:0] pushed_q[$];
    int unsigned start_cyc[$];
    logic [15:0] got_data[$];
    bit          got_last[$];
    int          suppress_idx = -1;
    int          ready_mode   = 0;
    bit          rd_pending   = 0;
    int unsigned rd_at        = 0;
    int          n_rden       = 0;
    int          n_fdone      = 0;
    int unsigned fdone_cyc    = 0;
    int unsigned last_acc_cyc = 0;
    int unsigned age          = 0;
    bit          held         = 0;
    logic [15:0] held_data    = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ADC/FIFO/sink model: drives inputs 1 time unit after posedge, observes at negedge.
    initial begin
        adc_done    = 1'b0;
        fifo_rdstb  = 1'b0;
        fifo_rddata = '0;
        out_ready   = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (done_at.size() > 0 && done_at[0] < cyc) void'(done_at.pop_front());
            adc_done = (done_at.size() > 0 && done_at[0] == cyc);
            if (adc_done) begin
                logic [15:0] d;
                void'(done_at.pop_front());
                d = 16'($urandom);
                fifo_q.push_back(d);
                pushed_q.push_back(d);
            end
            fifo_rdstb = rd_pending && (rd_at == cyc);
            if (fifo_rdstb) begin
                fifo_rddata = (fifo_q.size() > 0) ? fifo_q.pop_front() : 16'hDEAD;
                rd_pending  = 0;
            end else begin
                fifo_rddata = 16'($urandom);
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1, 0));
                default: out_ready = (age >= 5);
            endcase
            @(negedge clk);
            if (adc_start) begin
                int unsigned k;
                start_cyc.push_back(cyc);
                k = start_cyc.size() - 1;
                if (int'(k) != suppress_idx)
                    done_at.push_back(cyc + ((k < lat_q.size()) ? lat_q[k] : 1));
            end
            if (fifo_rden) begin
                n_rden++;
                check_eq("rden_single", 32'(rd_pending), 0);
                rd_pending = 1;
                rd_at      = cyc + $urandom_range(3, 1);
            end
            if (held) begin
                check_eq("hold_valid", 32'(out_valid), 1);
                if (out_valid) check_eq("hold_data", 32'(out_data), 32'(held_data));
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                if (out_last) last_acc_cyc = cyc;
                held = 0;
                age  = 0;
            end else if (out_valid) begin
                held      = 1;
                held_data = out_data;
                age++;
            end else begin
                held = 0;
                age  = 0;
            end
            if (frame_done) begin
                n_fdone++;
                fdone_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_bench();
        done_at.delete();
        fifo_q.delete();
        pushed_q.delete();
        start_cyc.delete();
        got_data.delete();
        got_last.delete();
        rd_pending = 0;
        n_rden     = 0;
        n_fdone    = 0;
        held       = 0;
        age        = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, 32'({busy, frame_done, err_timeout, adc_start, fifo_rden, out_valid, out_last}), 0);
        check_eq({tag, "_data"}, 32'(out_data), 0);
    endtask

    // One frame, checked against start times and words derived from the frame rules.
    task automatic run_frame(input int unsigned period, input int unsigned nsamp,
                             input int unsigned lmin, input int unsigned lmax,
                             input int rmode, input int supp);
        int unsigned f, n_eff, p_eff, n_starts, t, waited, err_cyc;
        clear_bench();
        lat_q.delete();
        for (int i = 0; i < 300; i++) lat_q.push_back($urandom_range(lmax, lmin));
        suppress_idx = supp;
        ready_mode   = rmode;
        n_eff        = (nsamp > 256) ? 256 : nsamp;
        p_eff        = (period < 2) ? 2 : period;
        n_starts     = (supp >= 0) ? int'(supp) + 1 : n_eff;

        step();
        cfg_period  = 16'(period);
        cfg_nsamp   = 9'(nsamp);
        frame_start = 1'b1;
        f           = cyc;
        step();
        frame_start = 1'b0;
        check_eq("busy_set", 32'(busy), 1);
        check_eq("err_clear", 32'(err_timeout), 0);
        cfg_period = 16'($urandom);
        cfg_nsamp  = 9'($urandom);
        if (n_eff > 0) begin
            step();
            step();
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
        end

        waited  = 0;
        err_cyc = 0;
        while (waited < 20000) begin
            if (n_fdone > 0) break;
            if (err_timeout) begin
                err_cyc = cyc;
                break;
            end
            step();
            waited++;
        end
        check_eq("frame_end", 32'(waited < 20000), 1);
        step();
        step();

        check_eq("start_count", start_cyc.size(), n_starts);
        t = f + 1;
        for (int k = 0; k < start_cyc.size() && k < int'(n_starts); k++) begin
            check_eq("start_cycle", start_cyc[k], t);
            t += (p_eff > lat_q[k]) ? p_eff : lat_q[k];
        end
        check_eq("busy_clear", 32'(busy), 0);

        if (supp >= 0) begin
            t = f + 1;
            for (int k = 0; k < supp; k++) t += (p_eff > lat_q[k]) ? p_eff : lat_q[k];
            check_eq("timeout_cycle", err_cyc, t + TIMEOUT + 1);
            check_eq("timeout_flag", 32'(err_timeout), 1);
            check_eq("timeout_no_done", n_fdone, 0);
            check_eq("timeout_no_rden", n_rden, 0);
        end else begin
            check_eq("word_count", got_data.size(), n_eff);
            check_eq("rden_count", n_rden, n_eff);
            for (int k = 0; k < got_data.size() && k < pushed_q.size(); k++) begin
                check_eq("word_data", 32'(got_data[k]), 32'(pushed_q[k]));
                check_eq("word_last", 32'(got_last[k]), 32'(k == int'(n_eff) - 1));
            end
            check_eq("fdone_count", n_fdone, 1);
            check_eq("fdone_cycle", fdone_cyc, (n_eff == 0) ? f + 2 : last_acc_cyc + 2);
            check_eq("err_idle", 32'(err_timeout), 0);
        end
    endtask

    initial begin
        int unsigned f;
        reset       = 1'b1;
        cfg_period  = '0;
        cfg_nsamp   = '0;
        frame_start = 1'b0;
        repeat (3) step();
        check_all_zero("reset_state");
        reset = 1'b0;
        step();

        run_frame(10, 4, 3, 3, 0, -1);
        run_frame(2, 3, 8, 8, 0, -1);
        run_frame(7, 0, 1, 1, 0, -1);
        run_frame(1, 5, 1, 1, 0, -1);
        run_frame(2, 300, 1, 4, 1, -1);
        run_frame(5, 6, 1, 12, 2, -1);
        for (int i = 0; i < 4; i++)
            run_frame($urandom_range(20, 0), $urandom_range(20, 0), 1, 15, 1, -1);
`ifdef MTI_FRAME_TIMEOUT_EN
        run_frame(10, 4, 3, 3, 0, 1);
        run_frame(10, 2, 3, 3, 0, -1);
`endif

        clear_bench();
        lat_q.delete();
        for (int i = 0; i < 300; i++) lat_q.push_back(3);
        suppress_idx = -1;
        ready_mode   = 0;
        cfg_period   = 16'd10;
        cfg_nsamp    = 9'd8;
        frame_start  = 1'b1;
        f            = cyc;
        step();
        frame_start = 1'b0;
        while (cyc < f + 15) step();
        check_eq("mid_acq_busy", 32'(busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("reset_mid_acq");
        clear_bench();
        repeat (20) step();
        check_eq("idle_after_reset", start_cyc.size() + n_rden + n_fdone, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
